// File: rtl/vram_arb_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared definitions for the VRAM arbiter: CPU-side state encoding, default
// widths, the video fetch spacing and the helper that turns that spacing into
// an hpos mask.
// -----------------------------------------------------------------------------
package vram_arb_pkg;

  localparam int DEF_ADDR_W      = 13;  // VRAM address width (words)
  localparam int DEF_DATA_W      = 8;   // VRAM word width (8 pixels at 1 bpp)
  localparam int DEF_FETCH_SHIFT = 3;   // one video slot every 2^n pixels
  localparam int HPOS_W          = 10;  // hpos/vpos width from hvsync_generator

  // CPU access sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    HOLD    = 2'd3
  } cpu_state_t;

  // Low hpos bits that must all be zero for a video slot.
  function automatic logic [HPOS_W-1:0] slot_mask(input int shift);
    return HPOS_W'((1 << shift) - 1);
  endfunction

  localparam logic [HPOS_W-1:0] SLOT_MASK = slot_mask(DEF_FETCH_SHIFT);

endpackage

// File: rtl/vram_fetch_addr_gen.sv
// -----------------------------------------------------------------------------
// vram_fetch_addr_gen
// Decodes video fetch slots from the raster position and keeps the scan-out
// word address. The address wraps modulo 2^ADDR_W and is forced to zero for
// the slot at the frame origin (hpos==0 && vpos==0).
//
// Ports:
//   clk         in   pixel clock, rising edge
//   reset       in   asynchronous, active-high
//   hpos, vpos  in   raster position
//   display_on  in   active-video flag
//   vslot       out  this cycle is a video fetch slot
//   fetch_addr  out  word address to fetch in this cycle's slot
// -----------------------------------------------------------------------------
module vram_fetch_addr_gen
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FETCH_SHIFT = DEF_FETCH_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HPOS_W-1:0] hpos,
  input  logic [HPOS_W-1:0] vpos,
  input  logic              display_on,
  output logic              vslot,
  output logic [ADDR_W-1:0] fetch_addr
);

  localparam logic [HPOS_W-1:0] L_MASK = slot_mask(FETCH_SHIFT);

  logic [ADDR_W-1:0] r_fetch_addr;
  logic              w_frame_start;

  assign w_frame_start = (hpos == '0) && (vpos == '0);
  assign vslot         = display_on && ((hpos & L_MASK) == '0);

  // The frame-origin clear acts on the current cycle's slot, so the
  // override is combinational rather than waiting for the register.
  assign fetch_addr = w_frame_start ? '0 : r_fetch_addr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_addr <= '0;
    end else if (vslot) begin
      r_fetch_addr <= fetch_addr + ADDR_W'(1);
    end else if (w_frame_start) begin
      r_fetch_addr <= '0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM between the scan-out fetch path and
// a CPU request port. Video slots are fixed and always win; the CPU is served
// in any other eligible cycle through a small IDLE/WR_ACK/RD_WAIT/HOLD
// sequencer that limits it to one access per three cycles.
//
// Build option: VRAM_ARB_BLANK_ONLY_EN -- when defined, CPU grants are made
// only while display_on is low.
//
// Ports:
//   clk, reset               pixel clock; asynchronous active-high reset
//   hpos, vpos, display_on   raster timing from hvsync_generator
//   cpu_req/we/addr/wdata    CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata       one-cycle completion pulse and read data
//   ram_en/we/addr/wdata     combinational RAM controls
//   ram_rdata                RAM read data, one cycle after ram_en
//   vid_data, vid_valid      fetched scan-out word and its update pulse
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FETCH_SHIFT = DEF_FETCH_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HPOS_W-1:0] hpos,
  input  logic [HPOS_W-1:0] vpos,
  input  logic              display_on,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid
);

  cpu_state_t        r_state;
  cpu_state_t        w_state_nxt;
  logic              w_vslot;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_cpu_eligible;
  logic              w_grant;

  logic              r_slot_d1;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;

  vram_fetch_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FETCH_SHIFT (FETCH_SHIFT)
  ) u_fetch (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .vslot      (w_vslot),
    .fetch_addr (w_fetch_addr)
  );

`ifdef VRAM_ARB_BLANK_ONLY_EN
  // CPU waits for blanking so the RAM never alternates owners in active video.
  assign w_cpu_eligible = !w_vslot && !display_on;
`else
  assign w_cpu_eligible = !w_vslot;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = w_fetch_addr;
    ram_wdata   = cpu_wdata;

    case (r_state)
      IDLE: begin
        if (cpu_req && w_cpu_eligible) begin
          w_grant     = 1'b1;
          w_state_nxt = cpu_we ? WR_ACK : RD_WAIT;
        end
      end
      WR_ACK:  w_state_nxt = HOLD;
      RD_WAIT: w_state_nxt = HOLD;
      // HOLD blocks a second grant while the requester still sees its ack.
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // The RAM is kept quiet for as long as reset is asserted.
    if (!reset) begin
      if (w_vslot) begin
        ram_en   = 1'b1;
        ram_addr = w_fetch_addr;
      end else if (w_grant) begin
        ram_en   = 1'b1;
        ram_we   = cpu_we;
        ram_addr = cpu_addr;
      end
    end
  end

  // Video data lands one cycle after its slot and is registered on the
  // following edge; CPU read data is captured in RD_WAIT so a video slot in
  // that cycle can reuse the RAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_d1   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_slot_d1   <= w_vslot;
      r_vid_valid <= r_slot_d1;
      if (r_slot_d1) begin
        r_vid_data <= ram_rdata;
      end
      // Writes ack in WR_ACK (grant+1); reads ack in the cycle after RD_WAIT.
      r_cpu_ack <= (w_grant && cpu_we) || (r_state == RD_WAIT);
      if (r_state == RD_WAIT) begin
        r_cpu_rdata <= ram_rdata;
      end
    end
  end

  assign vid_data  = r_vid_data;
  assign vid_valid = r_vid_valid;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Scoreboard bench for vram_arbiter. A driver steps raster timing and CPU
// requests one cycle at a time; a reference model derived from the arbitration
// rules predicts RAM ownership each cycle and queues the expected video words
// and CPU acks. A separate monitor pops and compares whenever vid_valid or
// cpu_ack is seen. A behavioural VRAM sits on the RAM port.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 8;
  localparam int FETCH_SHIFT = 3;
  localparam int MEM_WORDS   = 1 << ADDR_W;
  localparam int H_TOTAL     = 48;
  localparam int H_ACT       = 32;
  localparam int V_TOTAL     = 4;
  localparam int V_ACT       = 3;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic [9:0]        hpos       = '0;
  logic [9:0]        vpos       = '0;
  logic              display_on = 1'b0;
  logic              cpu_req    = 1'b0;
  logic              cpu_we     = 1'b0;
  logic [ADDR_W-1:0] cpu_addr   = '0;
  logic [DATA_W-1:0] cpu_wdata  = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata  = '0;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  vram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FETCH_SHIFT (FETCH_SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous VRAM (read-before-write).
  logic [DATA_W-1:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } vid_exp_t;

  typedef struct {
    int                due;
    bit                is_read;
    logic [DATA_W-1:0] data;
  } ack_exp_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  vid_exp_t          vid_q[$];
  ack_exp_t          ack_q[$];
  op_t               ops[$];
  op_t               cur;
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];

  // Reference model state.
  logic [ADDR_W-1:0] m_fetch    = '0;
  int                next_free  = 0;
  int                ack_due    = 0;
  bit                cpu_active = 1'b0;
  bit                granted    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return DATA_W'(a) ^ DATA_W'((a >> 8) * 37);
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.addr  = ADDR_W'($urandom_range(0, 31)) | (($urandom_range(0, 1) != 0) ? ADDR_W'(13'h0100) : '0);
    o.wdata = DATA_W'($urandom);
    return o;
  endfunction

  // One pixel clock: set inputs at the negedge, predict, then check RAM port.
  task automatic drive_cycle(input int hp, input int vp, input bit de, input int req_pct);
    bit                fs;
    bit                vs;
    bit                gr;
    logic [ADDR_W-1:0] exp_vaddr;
    vid_exp_t          ve;
    ack_exp_t          ae;
    @(negedge clk);
    hpos       = 10'(hp);
    vpos       = 10'(vp);
    display_on = de;
    if (granted && cyc > ack_due) begin
      cpu_active = 1'b0;
      granted    = 1'b0;
    end
    if (!cpu_active && ops.size() > 0 && $urandom_range(1, 100) <= req_pct) begin
      cur        = ops.pop_front();
      cpu_active = 1'b1;
    end
    cpu_req   = cpu_active;
    cpu_we    = cur.we;
    cpu_addr  = cur.addr;
    cpu_wdata = cur.wdata;

    fs = (hp == 0) && (vp == 0);
    vs = de && ((hp % (1 << FETCH_SHIFT)) == 0);
    if (fs) m_fetch = '0;
    gr = cpu_active && !granted && !vs && (cyc >= next_free);
`ifdef VRAM_ARB_BLANK_ONLY_EN
    gr = gr && !de;
`endif
    exp_vaddr = m_fetch;
    if (vs) begin
      ve.due  = cyc + 2;
      ve.data = ref_mem[m_fetch];
      vid_q.push_back(ve);
      m_fetch = m_fetch + ADDR_W'(1);
    end
    if (gr) begin
      granted    = 1'b1;
      next_free  = cyc + 3;
      ack_due    = cyc + (cur.we ? 1 : 2);
      ae.due     = ack_due;
      ae.is_read = !cur.we;
      ae.data    = ref_mem[cur.addr];
      ack_q.push_back(ae);
      if (cur.we) ref_mem[cur.addr] = cur.wdata;
    end

    #1;
    check("ram_en", 32'(ram_en), 32'(vs || gr));
    check("ram_we", 32'(ram_we), 32'(gr && cur.we));
    if (vs) check("ram_addr_video", 32'(ram_addr), 32'(exp_vaddr));
    if (gr) begin
      check("ram_addr_cpu", 32'(ram_addr), 32'(cur.addr));
      if (cur.we) check("ram_wdata", 32'(ram_wdata), 32'(cur.wdata));
    end
  endtask

  task automatic quiet_release();
    @(negedge clk);
    display_on = 1'b0;
    hpos       = 10'd8;
    vpos       = 10'd1;
    cpu_req    = 1'b0;
    reset      = 1'b0;
    m_fetch    = '0;
    next_free  = 0;
    cpu_active = 1'b0;
    granted    = 1'b0;
  endtask

  task automatic reset_hold_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("reset_ram_en", 32'(ram_en), 32'(0));
      check("reset_ram_we", 32'(ram_we), 32'(0));
      check("reset_cpu_ack", 32'(cpu_ack), 32'(0));
      check("reset_vid_valid", 32'(vid_valid), 32'(0));
      check("reset_vid_data", 32'(vid_data), 32'(0));
      check("reset_cpu_rdata", 32'(cpu_rdata), 32'(0));
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    vid_exp_t ve;
    ack_exp_t ae;
    forever begin
      @(posedge clk);
      #2;
      if (vid_valid) begin
        if (vid_q.size() == 0) begin
          check("vid_valid_unexpected", 32'(vid_valid), 32'(0));
        end else begin
          ve = vid_q.pop_front();
          check("vid_valid_cycle", 32'(cyc), 32'(ve.due));
          check("vid_data", 32'(vid_data), 32'(ve.data));
        end
      end
      while (vid_q.size() > 0 && vid_q[0].due < cyc) begin
        ve = vid_q.pop_front();
        check("vid_valid_missing", 32'(cyc), 32'(ve.due));
      end
      if (cpu_ack) begin
        if (ack_q.size() == 0) begin
          check("cpu_ack_unexpected", 32'(cpu_ack), 32'(0));
        end else begin
          ae = ack_q.pop_front();
          check("cpu_ack_cycle", 32'(cyc), 32'(ae.due));
          if (ae.is_read) check("cpu_rdata", 32'(cpu_rdata), 32'(ae.data));
        end
      end
      while (ack_q.size() > 0 && ack_q[0].due < cyc) begin
        ae = ack_q.pop_front();
        check("cpu_ack_missing", 32'(cyc), 32'(ae.due));
      end
    end
  end

  initial begin
    cur = '{we: 1'b0, addr: '0, wdata: '0};
    for (int a = 0; a < MEM_WORDS; a++) begin
      mem[a]     <= init_word(a);
      ref_mem[a] = init_word(a);
    end
    mem[0]     <= 8'hA5;
    ref_mem[0] = 8'hA5;

    // Reset held with a would-be slot and a pending CPU write on the inputs.
    reset      = 1'b1;
    display_on = 1'b1;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    reset_hold_checks(3);
    quiet_release();

    // Directed write then read-back of 0x0100 during blanking.
    ops.push_back('{we: 1'b1, addr: 13'h0100, wdata: 8'h3C});
    ops.push_back('{we: 1'b0, addr: 13'h0100, wdata: 8'h00});
    for (int i = 0; i < 12; i++) drive_cycle(40, 3, 1'b0, 100);

    // Full frames with random CPU traffic interleaved with video slots.
    for (int i = 0; i < 40; i++) ops.push_back(rand_op());
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < V_TOTAL; v++)
        for (int h = 0; h < H_TOTAL; h++)
          drive_cycle(h, v, (h < H_ACT) && (v < V_ACT), 60);

    // Continuous requests through blanking: one grant every third cycle.
    ops.delete();
    for (int i = 0; i < 20; i++) ops.push_back(rand_op());
    for (int i = 0; i < 70; i++) drive_cycle(40, 3, 1'b0, 100);
    for (int i = 0; i < 8; i++) drive_cycle(40, 3, 1'b0, 0);

    // Every cycle a slot, no frame start: fetch address wraps past 0x1FFF.
    for (int i = 0; i < MEM_WORDS + 16; i++) drive_cycle(8, 1, 1'b1, 0);
    drive_cycle(0, 0, 1'b1, 0);
    drive_cycle(8, 0, 1'b1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(40, 3, 1'b0, 0);

    // Reset asserted while a read sits in RD_WAIT.
    ops.delete();
    ops.push_back('{we: 1'b0, addr: 13'h0100, wdata: 8'h00});
    for (int i = 0; i < 20 && !granted; i++) drive_cycle(40, 3, 1'b0, 100);
    check("reset_read_granted", 32'(granted), 32'(1));
    @(negedge clk);
    reset      = 1'b1;
    display_on = 1'b1;
    hpos       = '0;
    vpos       = '0;
    cpu_req    = 1'b0;
    cpu_active = 1'b0;
    granted    = 1'b0;
    vid_q.delete();
    ack_q.delete();
    reset_hold_checks(3);
    quiet_release();
    drive_cycle(8, 1, 1'b1, 0);

    // Traffic after reset proves the sequencer is back in IDLE.
    for (int i = 0; i < 20; i++) ops.push_back(rand_op());
    for (int v = 1; v < V_TOTAL; v++)
      for (int h = 0; h < H_TOTAL; h++)
        drive_cycle(h, v, (h < H_ACT) && (v < V_ACT), 70);
    for (int i = 0; i < 12; i++) drive_cycle(40, 3, 1'b0, 0);

    check("vid_queue_drained", 32'(vid_q.size()), 32'(0));
    check("ack_queue_drained", 32'(ack_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port synchronous video RAM between two requesters. The first is the scan-out fetch path, driven by the hvsync_generator hpos/vpos/display_on outputs. The second is a CPU-side request port. Video fetches own fixed, non-negotiable slots; the CPU is served in every other cycle. The block sits between hvsync_generator, the VRAM instance and the pixel shifter that feeds the rgb/vde path.

Parameters:
ADDR_W, 13, VRAM address width (words)
DATA_W, 8, VRAM word width; one word = 8 pixels at 1 bpp
FETCH_SHIFT, 3, video slot every 2^FETCH_SHIFT pixels (slot when hpos[FETCH_SHIFT-1:0]==0)

Ports:
clk  in  1  pixel clock, rising edge
reset  in  1  asynchronous, active-high
hpos  in  10  horizontal position from hvsync_generator
vpos  in  10  vertical position from hvsync_generator
display_on  in  1  active-video flag from hvsync_generator
cpu_req  in  1  CPU request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
ram_en  out  1  RAM enable (combinational)
ram_we  out  1  RAM write enable (combinational)
ram_addr  out  ADDR_W  RAM address (combinational)
ram_wdata  out  DATA_W  RAM write data (combinational)
ram_rdata  in  DATA_W  RAM read data, one cycle after ram_en
vid_data  out  DATA_W  fetched scan-out word
vid_valid  out  1  one-cycle pulse when vid_data updates

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, vid_data=0, vid_valid=0, fetch_addr=0, state=IDLE. ram_en and ram_we are 0 while reset is asserted.
- Video slot (vslot) = display_on && hpos[FETCH_SHIFT-1:0]==0. It always wins arbitration, and no CPU access is ever granted in a vslot cycle.
- In a vslot cycle: ram_en=1, ram_we=0, ram_addr=fetch_addr. At the next edge, fetch_addr increments modulo 2^ADDR_W.
- Video data path:
  - Slot cycle t: ram_rdata is valid at t+1.
  - At the edge ending t+1, vid_data is registered and vid_valid is set for exactly one cycle (t+2). Total latency is 2 cycles.
- Frame start: when hpos==0 && vpos==0, fetch_addr is forced to 0 for that cycle's slot. The counter then continues 1, 2, ... from there.
- CPU state machine:
  - IDLE: if cpu_req && !vslot, grant. ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata. Go to WR_ACK if cpu_we, else RD_WAIT. If a vslot blocks the request, stay in IDLE and retry next cycle.
  - WR_ACK: cpu_ack=1 this cycle, then go to HOLD.
  - RD_WAIT: capture ram_rdata into cpu_rdata and pulse cpu_ack next cycle, then go to HOLD.
  - HOLD: one cycle in which no new grant is made, so the still-high cpu_req cannot be double-served. Then go to IDLE.
  - Resulting CPU latency, measured from the grant cycle t: write ack at t+1, read ack and data at t+2.
- Throughput: at most one CPU access per 3 cycles. Worst-case wait for a pending request before grant is 1 cycle during active video.
- Simultaneous CPU request and vslot: video is served and the CPU waits. The CPU is never dropped.
- A CPU read in flight is unaffected by a vslot in the next cycle. The RAM port is free because read data is captured rather than re-requested.
- Dropping cpu_req before cpu_ack is a protocol violation. An already-granted access still completes and acks.
- Reset mid-access: the access is abandoned, no ack is issued, and fetch_addr returns to 0.
- Blanking (display_on=0): no vslots; the CPU owns every eligible cycle.

Optional Feature:
VRAM_ARB_BLANK_ONLY_EN
- Defined: CPU grants are made only when display_on=0. Requests pending during active video wait for blanking, which removes RAM contention glitches for slow RAM models.
- Undefined: interleaved access as described in Behaviour.

Decomposition:
- Package vram_arb_pkg holds:
  - state encoding: IDLE, WR_ACK, RD_WAIT, HOLD
  - default widths: ADDR_W, DATA_W
  - FETCH_SHIFT constant
  - slot-mask helper constant
- One sub-module, vram_fetch_addr_gen, holds the vslot decode, frame-start clear and wrapping fetch_addr counter. Its outputs are vslot and fetch_addr.

Test Plan:
- Reset released; hpos=0, vpos=0, display_on=1 → ram_addr=0 at that cycle. Slots at hpos=8, 16 use addresses 1, 2. With RAM data 0xA5 at addr 0, vid_data=0xA5 and vid_valid pulses 2 cycles after the hpos=0 slot.
- CPU write addr 0x0100, data 0x3C during blanking → ram_we=1 in the grant cycle, cpu_ack one cycle later. A read back of 0x0100 returns cpu_rdata=0x3C with cpu_ack 2 cycles after its grant.
- cpu_req raised in the same cycle as an hpos=16 slot → ram_addr=fetch_addr that cycle. CPU grant follows 1 cycle later; vid_valid and cpu_ack are both correct.
- cpu_req held continuously through blanking → grants every 3rd cycle exactly, and each request is acked exactly once.
- fetch_addr at 0x1FFF with a slot → next slot uses 0x0000. A frame start at any fetch_addr forces 0.
- Assert reset in RD_WAIT → no cpu_ack; after release, state=IDLE and fetch_addr=0. With VRAM_ARB_BLANK_ONLY_EN defined, a request made at display_on=1 is granted only in the first display_on=0 cycle.
